// File: rtl/dir_input_encoder.sv
`default_nettype none
// dir_input_encoder: synchronise/debounce/edge-detect five buttons; holds snake direction and start level.
// Build option REVERSE_BLOCK_EN masks direction events opposite the current movement.
module dir_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [3:0] movement,
  output logic       dir_valid,
  output logic       start
);

  localparam int               NB       = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q;
  logic [NB-1:0]    sync2_q;
  logic [NB-1:0]    stable_q;
  logic [NB-1:0]    stable_d;
  logic [NB-1:0]    prev_q;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    press;
  logic [3:0]       dir_masked;
  logic [3:0]       winner;
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       movement_q;
  logic [3:0]       movement_d;
  logic             dir_valid_q;
  logic             dir_valid_d;

  // Bit order {start, right, left, down, up}; low four bits line up with movement.
  assign raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = stable_q & ~prev_q;

`ifdef REVERSE_BLOCK_EN
  // Opposite pairs are up<->down and left<->right.
  assign dir_masked = press[3:0] &
                      ~{movement_q[2], movement_q[3], movement_q[0], movement_q[1]};
`else
  assign dir_masked = press[3:0];
`endif

  always_comb begin
    winner = 4'b0000;
    if (dir_masked[0]) begin
      winner = 4'b0001;
    end else if (dir_masked[1]) begin
      winner = 4'b0010;
    end else if (dir_masked[2]) begin
      winner = 4'b0100;
    end else if (dir_masked[3]) begin
      winner = 4'b1000;
    end
  end

  always_comb begin
    state_d     = state_q;
    movement_d  = movement_q;
    dir_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press[4]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if ((winner != 4'b0000) && (winner != movement_q)) begin
          movement_d  = winner;
          dir_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
      state_q     <= IDLE;
      movement_q  <= 4'b0001;
      dir_valid_q <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      prev_q      <= stable_q;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q     <= state_d;
      movement_q  <= movement_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  assign movement  = movement_q;
  assign dir_valid = dir_valid_q;
  assign start     = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_dir_input_encoder.sv
`default_nettype none
// tb_dir_input_encoder: directed vectors with a window-based behavioural model and literal checkpoints.
module tb_dir_input_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] btn = '0;  // {start, right, left, down, up}
  logic [3:0] movement;
  logic       dir_valid;
  logic       start;

  int vectors = 0;
  int errors  = 0;
  int dv_cnt  = 0;
  int dv0     = 0;
  bit chk_en  = 1'b0;

  dir_input_encoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_up   (btn[0]),
    .btn_down (btn[1]),
    .btn_left (btn[2]),
    .btn_right(btn[3]),
    .btn_start(btn[4]),
    .movement (movement),
    .dir_valid(dir_valid),
    .start    (start)
  );

  always #5 clk = ~clk;

  // Model: a button's stable level flips once the last D synchronised samples all disagree with it.
  logic [3:0] m_mov;
  logic       m_dv;
  logic       m_run;
  logic [4:0] m_stable;
  logic [4:0] m_press;
  logic [4:0] m_np;
  logic [4:0] h [0:D];
  int         m_win;
  bit         m_diff;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_mov = 4'b0001; m_dv = 1'b0; m_run = 1'b0;
        m_stable = '0; m_press = '0;
        for (int k = 0; k <= D; k++) h[k] = '0;
      end else begin
        m_dv = 1'b0;
        if (!m_run) begin
          if (m_press[4]) m_run = 1'b1;
        end else begin
          m_win = -1;
          for (int d = 0; d < 4 && m_win < 0; d++) begin
`ifdef REVERSE_BLOCK_EN
            if (m_press[d] && (m_mov != 4'(1 << (d ^ 1)))) m_win = d;
`else
            if (m_press[d]) m_win = d;
`endif
          end
          if (m_win >= 0 && m_mov != 4'(1 << m_win)) begin
            m_mov = 4'(1 << m_win);
            m_dv  = 1'b1;
          end
        end
        m_np = '0;
        for (int b = 0; b < 5; b++) begin
          m_diff = 1'b1;
          for (int k = 1; k <= D; k++) if (h[k][b] == m_stable[b]) m_diff = 1'b0;
          if (m_diff) begin
            m_stable[b] = ~m_stable[b];
            if (m_stable[b]) m_np[b] = 1'b1;
          end
        end
        m_press = m_np;
        for (int k = D; k >= 1; k--) h[k] = h[k-1];
        h[0] = btn;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && chk_en) begin
        chk("model_movement", {4'b0, movement}, {4'b0, m_mov});
        chk("model_dir_valid", {7'b0, dir_valid}, {7'b0, m_dv});
        chk("model_start", {7'b0, start}, {7'b0, m_run});
      end
      if (dir_valid === 1'b1) dv_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    btn     = '0;
    step(3);
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    step(10);
    btn = '0;
    step(10);
  endtask

  initial begin
    step(3);
    chk_en = 1'b1;
    chk("reset_movement", {4'b0, movement}, 8'h01);
    chk("reset_dir_valid", {7'b0, dir_valid}, 8'h00);
    chk("reset_start", {7'b0, start}, 8'h00);
    reset_n = 1'b1;
    step(2);

    // IDLE ignores direction events
    dv0 = dv_cnt;
    btn = 5'b01000;
    step(20);
    btn = '0;
    step(8);
    chk("idle_movement", {4'b0, movement}, 8'h01);
    chk("idle_pulses", 8'(dv_cnt - dv0), 8'h00);
    chk("idle_start", {7'b0, start}, 8'h00);

    // start latency: first sampled at edge 1, visible at edge D+3
    btn = 5'b10000;
    step(D + 2);
    chk("start_edge6", {7'b0, start}, 8'h00);
    step(1);
    chk("start_edge7", {7'b0, start}, 8'h01);
    step(3);
    btn = '0;
    step(10);
    chk("start_sticky", {7'b0, start}, 8'h01);

    // left press in RUN, pulse exactly at edge 7
    dv0 = dv_cnt;
    btn = 5'b00100;
    step(D + 2);
    chk("left_edge6_mov", {4'b0, movement}, 8'h01);
    chk("left_edge6_dv", {7'b0, dir_valid}, 8'h00);
    step(1);
    chk("left_edge7_mov", {4'b0, movement}, 8'h04);
    chk("left_edge7_dv", {7'b0, dir_valid}, 8'h01);
    step(1);
    chk("left_edge8_dv", {7'b0, dir_valid}, 8'h00);
    step(10);
    btn = '0;
    step(10);
    chk("left_one_pulse", 8'(dv_cnt - dv0), 8'h01);

    // bounce on btn_up never reaches the stable level
    press(5'b00001);
    press(5'b01000);
    chk("right_movement", {4'b0, movement}, 8'h08);
    dv0 = dv_cnt;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      step(2);
    end
    step(10);
    chk("bounce_movement", {4'b0, movement}, 8'h08);
    chk("bounce_pulses", 8'(dv_cnt - dv0), 8'h00);

    // simultaneous events and reversal handling
    do_reset();
    press(5'b10000);
    press(5'b00100);
    chk("pri_setup_mov", {4'b0, movement}, 8'h04);
    dv0 = dv_cnt;
    press(5'b01001);
    chk("pri_up_wins", {4'b0, movement}, 8'h01);
    chk("pri_one_pulse", 8'(dv_cnt - dv0), 8'h01);
    dv0 = dv_cnt;
    press(5'b00010);
`ifdef REVERSE_BLOCK_EN
    chk("rev_blocked_mov", {4'b0, movement}, 8'h01);
    chk("rev_blocked_pulses", 8'(dv_cnt - dv0), 8'h00);
`else
    chk("rev_accept_mov", {4'b0, movement}, 8'h02);
    chk("rev_accept_pulses", 8'(dv_cnt - dv0), 8'h01);
`endif

    // asynchronous reset mid-run
    press(5'b00100);
    chk("prereset_mov", {4'b0, movement}, 8'h04);
    chk("prereset_start", {7'b0, start}, 8'h01);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_mov", {4'b0, movement}, 8'h01);
    chk("async_reset_dv", {7'b0, dir_valid}, 8'h00);
    chk("async_reset_start", {7'b0, start}, 8'h00);

    // start held across reset release is debounced afresh and counts as a press
    btn = 5'b10000;
    step(2);
    reset_n = 1'b1;
    step(12);
    chk("held_start_fresh", {7'b0, start}, 8'h01);
    btn = '0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
